sc_dmem_dma: RTL and testbench
==============================

Name: sc_dmem_dma

Overview:
- Bus initiator that drives the data-memory load/store port (addr, datain, we, dataout) to copy a block of words from a source address to a destination address.
- It is the master-side counterpart of the data memory / memory-mapped I/O responder.
- Used for block moves inside data RAM, for sampling input ports (addr[7]=1 region) into RAM, and for streaming RAM to the output port register.
- Sits beside the CPU. Muxing memory-port ownership between CPU and DMA is done outside this block.

Parameters:
- LEN_W, 6, width of length and progress counters (max transfer 2^LEN_W-1 words)
- STRIDE, 4, byte increment applied to both addresses per word

Ports:
- clock  in  1  system clock; all state changes on rising edge
- clrn  in  1  synchronous active-low reset
- start  in  1  one-cycle request; honoured only in IDLE
- abort  in  1  cancel an active transfer
- src_addr  in  32  byte address of first source word
- dst_addr  in  32  byte address of first destination word
- len  in  LEN_W  number of words to copy
- mem_dataout  in  32  read data returned by data memory / I/O for mem_addr
- mem_addr  out  32  address presented to data memory
- mem_datain  out  32  write data presented to data memory
- mem_we  out  1  write enable to data memory
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse on successful completion
- err  out  1  sticky alignment error; cleared by the next accepted start
- words_done  out  LEN_W  words written so far in current/last transfer

Behaviour:
- Reset (clrn=0 at a rising edge): state=IDLE. Outputs: mem_addr=0, mem_datain=0, mem_we=0, busy=0, done=0, err=0, words_done=0. Reset mid-transfer discards the transfer. No write occurs in the cycle after reset.
- States: IDLE, RD, WR, DONE.
- All outputs are driven from registers or decoded from state only. mem_we=1 exactly when state=WR, so it is glitch-free.
- IDLE, start=1:
  - If src_addr[1:0]!=0 or dst_addr[1:0]!=0: err<=1, stay IDLE, no bus activity.
  - Else if len==0: err<=0, words_done<=0, go to DONE.
  - Else: latch src, dst, remaining=len; err<=0; words_done<=0; go to RD.
- IDLE, start=0: hold. mem_we=0; mem_addr holds its last value.
- RD:
  - Drive mem_addr=src, mem_we=0.
  - At the closing edge: capture mem_dataout into the data buffer, src<=src+STRIDE, go to WR.
- WR:
  - Drive mem_addr=dst, mem_datain=buffer, mem_we=1.
  - At the closing edge: dst<=dst+STRIDE, remaining<=remaining-1, words_done<=words_done+1.
  - If remaining==1, go to DONE; else go to RD.
- DONE: done=1, busy=0 for exactly one cycle, then IDLE.
- busy=1 in RD and WR only.
- Timing: start accepted at edge E. First RD cycle follows E. Word k (k=0..N-1) has RD in cycle 2k+1 and WR in cycle 2k+2. done is high in cycle 2N+1.
- Throughput: 2 cycles per word.
- Address arithmetic: 32-bit modulo. 0xFFFFFFFC+4 wraps to 0x00000000 with no error.
- Region: addresses are not checked. addr[7]=1 targets I/O on both read and write.
- Overlap: src/dst overlap is allowed. The copy proceeds in ascending order, so dst>src with overlap replicates data. This is the defined behaviour.
- start while busy or in DONE: ignored, no effect on the latched parameters.
- abort=1 in RD or WR:
  - The current cycle's bus action completes; a WR cycle still writes.
  - Next state is IDLE. done is not pulsed. words_done keeps its count.
- abort in IDLE/DONE: ignored.
- Simultaneous start and abort in IDLE: start wins.
- clrn has priority over abort and start.

Test Plan:
- Reset check: hold clrn=0 for 2 cycles with start=1 -> busy=0, mem_we=0, done=0, err=0, words_done=0 throughout and one cycle after release.
- Basic copy: preload RAM[0x00..0x0C]={11,22,33,44}; start with src=0x00, dst=0x40, len=4 -> mem_we high in cycles 2,4,6,8 at addresses 0x40,0x44,0x48,0x4C with data 11,22,33,44; done in cycle 9; words_done=4.
- I/O sample: in_port0=0x5, in_port1=0xA; copy src=0x80 (I/O), dst=0x10, len=1 -> RAM[0x10] equals the I/O read word; done in cycle 3.
- Errors and zero length:
  - start with src=0x02 -> err=1, no mem_we ever.
  - Then start with src=0, dst=4, len=0 -> err=0 and done in the next cycle, no write.
- Abort and ignored start: len=8 copy, assert abort during the 3rd WR (cycle 6) -> that write occurs, IDLE next, done never pulses, words_done=3. A start pulsed in cycle 4 of the same run is ignored.
- Overlap and wrap:
  - src=0x00, dst=0x04, len=3 with RAM[0]=7 -> RAM[4]=RAM[8]=RAM[0xC]=7.
  - src=0xFFFFFFFC, len=2 -> second read address is 0x00000000.

Source files
------------

// File: rtl/sc_dmem_dma_if.sv
// Data-memory load/store port shared between a bus initiator (master) and
// the data memory / memory-mapped I/O responder (slave).
interface sc_dmem_dma_if;
   logic [31:0] mem_addr;
   logic [31:0] mem_datain;
   logic        mem_we;
   logic [31:0] mem_dataout;

   modport master (
      output mem_addr,
      output mem_datain,
      output mem_we,
      input  mem_dataout
   );

   modport slave (
      input  mem_addr,
      input  mem_datain,
      input  mem_we,
      output mem_dataout
   );
endinterface

// File: rtl/sc_dmem_dma.sv
// Block-copy DMA initiator on the data-memory port: one read cycle then one
// write cycle per word, ascending addresses, with abort and alignment error.
module sc_dmem_dma #(
   parameter int LEN_W  = 6,
   parameter int STRIDE = 4
) (
   input  logic                 clock,
   input  logic                 clrn,
   input  logic                 start,
   input  logic                 abort,
   input  logic [31:0]          src_addr,
   input  logic [31:0]          dst_addr,
   input  logic [LEN_W-1:0]     len,
   sc_dmem_dma_if.master        mem,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [LEN_W-1:0]     words_done
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RD   = 2'd1;
   localparam logic [1:0] ST_WR   = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [31:0] STEP = 32'(STRIDE);

   logic [1:0]       state_reg,     state_next;
   logic [31:0]      src_reg,       src_next;
   logic [31:0]      dst_reg,       dst_next;
   logic [31:0]      addr_reg,      addr_next;
   logic [31:0]      buf_reg,       buf_next;
   logic [LEN_W-1:0] remaining_reg, remaining_next;
   logic [LEN_W-1:0] wd_reg,        wd_next;
   logic             err_reg,       err_next;

   logic misaligned;
   assign misaligned = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);

   always_comb begin
      state_next     = state_reg;
      src_next       = src_reg;
      dst_next       = dst_reg;
      addr_next      = addr_reg;
      buf_next       = buf_reg;
      remaining_next = remaining_reg;
      wd_next        = wd_reg;
      err_next       = err_reg;

      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               if (misaligned) begin
                  err_next = 1'b1;
               end else begin
                  err_next = 1'b0;
                  wd_next  = '0;
                  if (len == '0) begin
                     state_next = ST_DONE;
                  end else begin
                     src_next       = src_addr;
                     dst_next       = dst_addr;
                     remaining_next = len;
                     addr_next      = src_addr;
                     state_next     = ST_RD;
                  end
               end
            end
         end

         ST_RD: begin
            buf_next = mem.mem_dataout;
            src_next = src_reg + STEP;
            if (abort) begin
               state_next = ST_IDLE;
            end else begin
               addr_next  = dst_reg;
               state_next = ST_WR;
            end
         end

         ST_WR: begin
            // The write in this cycle always lands, even when aborting.
            dst_next       = dst_reg + STEP;
            remaining_next = remaining_reg - LEN_W'(1);
            wd_next        = wd_reg + LEN_W'(1);
            if (abort) begin
               state_next = ST_IDLE;
            end else if (remaining_reg == LEN_W'(1)) begin
               state_next = ST_DONE;
            end else begin
               addr_next  = src_reg;
               state_next = ST_RD;
            end
         end

         ST_DONE: begin
            state_next = ST_IDLE;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!clrn) begin
         state_reg     <= ST_IDLE;
         src_reg       <= '0;
         dst_reg       <= '0;
         addr_reg      <= '0;
         buf_reg       <= '0;
         remaining_reg <= '0;
         wd_reg        <= '0;
         err_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         src_reg       <= src_next;
         dst_reg       <= dst_next;
         addr_reg      <= addr_next;
         buf_reg       <= buf_next;
         remaining_reg <= remaining_next;
         wd_reg        <= wd_next;
         err_reg       <= err_next;
      end
   end

   // Address and data come straight from registers; we/busy/done decode state only.
   assign mem.mem_addr   = addr_reg;
   assign mem.mem_datain = buf_reg;
   assign mem.mem_we     = (state_reg == ST_WR);
   assign busy           = (state_reg == ST_RD) || (state_reg == ST_WR);
   assign done           = (state_reg == ST_DONE);
   assign err            = err_reg;
   assign words_done     = wd_reg;

endmodule

// File: tb/tb_sc_dmem_dma.sv
// Scoreboard bench for sc_dmem_dma: a word-level copy model predicts every bus
// cycle and done pulse; a negedge monitor pops and compares them.
module tb_sc_dmem_dma;
   localparam int LEN_W = 6;

   logic             clock = 1'b0;
   logic             clrn;
   logic             start;
   logic             abort;
   logic [31:0]      src_addr;
   logic [31:0]      dst_addr;
   logic [LEN_W-1:0] len;
   logic             busy;
   logic             done;
   logic             err;
   logic [LEN_W-1:0] words_done;

   sc_dmem_dma_if bus();

   sc_dmem_dma #(.LEN_W(LEN_W), .STRIDE(4)) dut (
      .clock      (clock),
      .clrn       (clrn),
      .start      (start),
      .abort      (abort),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .len        (len),
      .mem        (bus),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .words_done (words_done)
   );

   always #5 clock = ~clock;

   // Memory/I-O responder: addr[7]=0 -> 32-word RAM, addr[7]=1 -> I/O ports.
   logic [31:0] ram [0:31];
   logic [31:0] out_port;
   logic [31:0] in_port0;
   logic [31:0] in_port1;

   always_comb begin
      if (bus.mem_addr[7])
         bus.mem_dataout = bus.mem_addr[2] ? in_port1 : in_port0;
      else
         bus.mem_dataout = ram[bus.mem_addr[6:2]];
   end

   always @(posedge clock) begin
      if (bus.mem_we === 1'b1) begin
         if (bus.mem_addr[7]) out_port <= bus.mem_datain;
         else                 ram[bus.mem_addr[6:2]] <= bus.mem_datain;
      end
   end

   // Reference state
   logic [31:0] ref_ram [0:31];
   logic [31:0] ref_out;
   int          exp_wd;
   logic        exp_err;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int          kind;   // 0 read, 1 write, 2 done
      int          cyc;
      logic [31:0] addr;
      logic [31:0] data;
   } ev_t;

   ev_t exp_q[$];

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      if (a[7]) return a[2] ? in_port1 : in_port0;
      return ref_ram[a[6:2]];
   endfunction

   function automatic void ref_write(input logic [31:0] a, input logic [31:0] v);
      if (a[7]) ref_out = v;
      else      ref_ram[a[6:2]] = v;
   endfunction

   function automatic string kname(input int k);
      if (k == 0) return "RD";
      if (k == 1) return "WR";
      return "DONE";
   endfunction

   function automatic void push_ev(input int k, input int c, input logic [31:0] a,
                                   input logic [31:0] d);
      ev_t e;
      e.kind = k;
      e.cyc  = c;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end else begin
         $display("check %s ok: %h", name, act);
      end
   endtask

   task automatic check_ev(input int k, input logic [31:0] a, input logic [31:0] d);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_%s at cyc %0d: got addr=%h data=%h, required no activity",
                  kname(k), cyc, a, d);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.cyc != cyc || e.addr !== a || (k != 0 && e.data !== d)) begin
            errors++;
            $display("FAIL bus_%s: got %s cyc=%0d addr=%h data=%h, required %s cyc=%0d addr=%h data=%h",
                     kname(e.kind), kname(k), cyc, a, d, kname(e.kind), e.cyc, e.addr, e.data);
         end else begin
            $display("cyc=%0d %s addr=%h data=%h ok", cyc, kname(k), a, d);
         end
      end
   endtask

   // Monitor: any bus cycle or done pulse must match the head of the queue.
   always @(negedge clock) begin
      if (bus.mem_we === 1'b1)
         check_ev(1, bus.mem_addr, bus.mem_datain);
      else if (busy === 1'b1)
         check_ev(0, bus.mem_addr, 32'h0);
      if (done === 1'b1)
         check_ev(2, 32'h0, 32'(words_done));
   end

   // stop_kind: 0 none, 1 abort during cycle stop_t, 2 reset during cycle stop_t.
   // extra_t: cycle in which a (to-be-ignored) start is pulsed, 0 for none.
   task automatic xfer(input logic [31:0] s, input logic [31:0] d, input int n,
                       input int stop_kind, input int stop_t, input int extra_t,
                       input bit abort_with_start);
      bit          misal;
      int          tot;
      int          ops;
      int          c0;
      logic [31:0] v;
      @(negedge clock);
      c0    = cyc;
      misal = (s[1:0] != 2'b00) || (d[1:0] != 2'b00);
      if (misal) begin
         tot     = 1;
         exp_err = 1'b1;
      end else begin
         exp_err = 1'b0;
         if (n == 0)              begin ops = 0;      tot = 1;         end
         else if (stop_kind != 0) begin ops = stop_t; tot = stop_t;    end
         else                     begin ops = 2 * n;  tot = 2 * n + 1; end
         for (int t = 1; t <= ops; t++) begin
            int k;
            k = (t - 1) / 2;
            if (t % 2 == 1) begin
               push_ev(0, c0 + t, s + 32'(4 * k), 32'h0);
            end else begin
               v = ref_read(s + 32'(4 * k));
               ref_write(d + 32'(4 * k), v);
               push_ev(1, c0 + t, d + 32'(4 * k), v);
            end
         end
         exp_wd = (stop_kind == 2) ? 0 : ops / 2;
         if (n == 0 || stop_kind == 0) push_ev(2, c0 + tot, 32'h0, 32'(exp_wd));
      end
      $display("xfer src=%h dst=%h len=%0d stop=%0d@%0d extra=%0d", s, d, n, stop_kind,
               stop_t, extra_t);
      start    = 1'b1;
      abort    = abort_with_start;
      src_addr = s;
      dst_addr = d;
      len      = LEN_W'(n);
      for (int t = 1; t <= tot + 2; t++) begin
         @(negedge clock);
         if (t == 1) begin
            start    = 1'b0;
            abort    = 1'b0;
            src_addr = $urandom;
            dst_addr = $urandom;
            len      = LEN_W'($urandom);
         end
         if (stop_kind == 1 && t == stop_t)     abort = 1'b1;
         if (stop_kind == 1 && t == stop_t + 1) abort = 1'b0;
         if (stop_kind == 2 && t == stop_t)     clrn  = 1'b0;
         if (stop_kind == 2 && t == stop_t + 1) clrn  = 1'b1;
         if (extra_t != 0 && t == extra_t)      start = 1'b1;
         if (extra_t != 0 && t == extra_t + 1)  start = 1'b0;
      end
      chk("words_done", 32'(words_done), 32'(exp_wd));
      chk("err", {31'h0, err}, {31'h0, exp_err});
      chk("idle_after", {30'h0, busy, done}, 32'h0);
      chk("pending_events", 32'(exp_q.size()), 32'h0);
      exp_q.delete();
   endtask

   task automatic check_reset(input string name);
      chk(name, {22'h0, busy, bus.mem_we, done, err, words_done}, 32'h0);
      chk({name, "_addr"}, bus.mem_addr, 32'h0);
      chk({name, "_datain"}, bus.mem_datain, 32'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] s;
      logic [31:0] d;
      int          n;
      int          sk;
      int          st;
      int          et;
      int          lim;
      bit          aws;

      for (int i = 0; i < 32; i++) begin
         ram[i]     = $urandom;
         ref_ram[i] = ram[i];
      end
      ram[0] = 32'd11; ram[1] = 32'd22; ram[2] = 32'd33; ram[3] = 32'd44;
      for (int i = 0; i < 4; i++) ref_ram[i] = ram[i];
      in_port0 = 32'h5;
      in_port1 = 32'hA;
      out_port = 32'h0;
      ref_out  = 32'h0;
      exp_wd   = 0;
      exp_err  = 1'b0;

      clrn     = 1'b0;
      start    = 1'b1;
      abort    = 1'b0;
      src_addr = 32'h0;
      dst_addr = 32'h40;
      len      = LEN_W'(4);
      repeat (2) begin
         @(negedge clock);
         check_reset("reset");
      end
      clrn  = 1'b1;
      start = 1'b0;
      @(negedge clock);
      check_reset("post_reset");

      xfer(32'h00, 32'h40, 4, 0, 0, 0, 1'b0);           // basic copy
      xfer(32'h80, 32'h10, 1, 0, 0, 0, 1'b0);           // I/O sample
      xfer(32'h02, 32'h40, 3, 0, 0, 0, 1'b0);           // misaligned source
      xfer(32'h00, 32'h04, 0, 0, 0, 0, 1'b0);           // zero length clears err
      xfer(32'h20, 32'h60, 8, 1, 6, 4, 1'b0);           // abort in 3rd WR, ignored start
      ram[0]     = 32'd7;
      ref_ram[0] = 32'd7;
      xfer(32'h00, 32'h04, 3, 0, 0, 0, 1'b0);           // overlap replicates
      xfer(32'hFFFF_FFFC, 32'h20, 2, 0, 0, 0, 1'b0);    // address wrap
      xfer(32'h10, 32'h30, 2, 0, 0, 0, 1'b1);           // start beats abort in IDLE
      xfer(32'h00, 32'h50, 5, 2, 3, 0, 1'b0);           // reset mid-transfer
      xfer(32'h08, 32'h70, 3, 0, 0, 7, 1'b0);           // start during DONE ignored
      xfer(32'h00, 32'h80, 3, 0, 0, 0, 1'b0);           // stream to output port
      xfer(32'h04, 32'h43, 2, 0, 0, 0, 1'b0);           // misaligned destination

      for (int it = 0; it < 25; it++) begin
         s = 32'($urandom_range(0, 63)) << 2;
         d = 32'($urandom_range(0, 63)) << 2;
         if ($urandom_range(0, 9) == 0) s[1:0] = 2'($urandom_range(1, 3));
         if ($urandom_range(0, 9) == 0) d[1:0] = 2'($urandom_range(1, 3));
         n   = $urandom_range(0, 10);
         sk  = 0;
         st  = 0;
         et  = 0;
         aws = 1'($urandom_range(0, 1));
         if (s[1:0] == 2'b00 && d[1:0] == 2'b00 && n > 0) begin
            if ($urandom_range(0, 3) == 0) begin
               sk = 1;
               st = $urandom_range(1, 2 * n);
            end
            if ($urandom_range(0, 3) == 0) begin
               lim = (sk != 0) ? st : 2 * n + 1;
               if (lim >= 2) et = $urandom_range(2, lim);
            end
         end
         xfer(s, d, n, sk, st, et, aws);
      end

      @(negedge clock);
      for (int i = 0; i < 32; i++) chk($sformatf("ram[%0d]", i), ram[i], ref_ram[i]);
      chk("out_port", out_port, ref_out);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
